csr_spi_host: RTL and testbench



---
 rtl/csr_spi_pkg.sv | 19 +
 rtl/spi_sclk_gen.sv | 39 +++
 rtl/csr_spi_host.sv | 117 +++++++++++
 tb/tb_csr_spi_host.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/csr_spi_pkg.sv
// Shared opcodes, frame lengths and FSM encoding for the CSR SPI host.
package csr_spi_pkg;

  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b01;

  localparam int WR_FRAME_BITS = 16;
  localparam int RD_FRAME_BITS = 24;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_HOLD     = 3'd4,
    ST_RECOVER  = 3'd5
  } spi_state_e;

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period counter: strobes mark the last clk cycle of each SCLK low/high phase.
module spi_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic rise_strobe,
  output logic fall_strobe,
  output logic sample_strobe
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          phase;
  logic          half_end;

  assign half_end = enable && (cnt == LAST);

  // Phase restarts low whenever the frame is idle, so SETUP is always low phase cycle 0.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign rise_strobe   = half_end && !phase;
  assign fall_strobe   = half_end && phase;
  assign sample_strobe = half_end && phase;

endmodule

// File: rtl/csr_spi_host.sv
// SPI mode-0 master issuing single CSR read/write frames from a valid/ready request.
module csr_spi_host
  import csr_spi_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic                  spi_sclk,
  output logic                  spi_cs_n,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  localparam int FRAME_W = 2 + ADDR_WIDTH + 2 * DATA_WIDTH;

  spi_state_e            state, state_nx;
  logic [FRAME_W-1:0]    tx_sr;
  logic [DATA_WIDTH-1:0] rx_sr;
  logic [4:0]            bit_cnt;
  logic [4:0]            frame_bits;
  logic                  is_read;
  logic                  rise, fall, sample;
  logic                  accept, last_bit;

  assign accept     = req_valid && req_ready;
  assign frame_bits = is_read ? 5'(RD_FRAME_BITS) : 5'(WR_FRAME_BITS);
  assign last_bit   = (bit_cnt + 5'd1) == frame_bits;

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk          (clk),
    .rst          (rst),
    .enable       (state != ST_IDLE),
    .rise_strobe  (rise),
    .fall_strobe  (fall),
    .sample_strobe(sample)
  );

  always_ff @(posedge clk) begin
    state <= rst ? ST_IDLE : state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    busy      = 1'b1;
    spi_cs_n  = 1'b1;
    spi_sclk  = 1'b0;
    spi_mosi  = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_nx = ST_SETUP;
      end
      ST_SETUP, ST_SHIFT_LO: begin
        spi_cs_n = 1'b0;
        spi_mosi = tx_sr[FRAME_W-1];
        state_nx = rise ? ST_SHIFT_HI : ST_SHIFT_LO;
      end
      ST_SHIFT_HI: begin
        spi_cs_n = 1'b0;
        spi_sclk = 1'b1;
        spi_mosi = tx_sr[FRAME_W-1];
        if (fall) state_nx = last_bit ? ST_HOLD : ST_SHIFT_LO;
      end
      ST_HOLD: begin
        spi_cs_n = 1'b0;
        if (rise) state_nx = ST_RECOVER;
      end
      ST_RECOVER: begin
        if (fall) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_sr     <= '0;
      rx_sr     <= '0;
      bit_cnt   <= '0;
      is_read   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= (state == ST_HOLD) && rise;
      if (accept) begin
        // Reads carry a zero turnaround byte and a zero capture byte.
        tx_sr   <= {req_write ? OP_WRITE : OP_READ, req_addr,
                    req_write ? req_wdata : {DATA_WIDTH{1'b0}}, {DATA_WIDTH{1'b0}}};
        is_read <= !req_write;
        bit_cnt <= '0;
      end
      if (state == ST_SHIFT_HI && sample)
        rx_sr <= {rx_sr[DATA_WIDTH-2:0], spi_miso};
      if (state == ST_SHIFT_HI && fall) begin
        tx_sr <= tx_sr << 1;
        if (bit_cnt != frame_bits) bit_cnt <= bit_cnt + 5'd1;
      end
      // Only the last byte shifted in survives in rx_sr, i.e. the capture byte.
      if (state == ST_HOLD && rise && is_read)
        rsp_rdata <= rx_sr;
    end
  end

endmodule

// File: tb/tb_csr_spi_host.sv
// Scoreboard bench: stimulus pushes expected frames, a negedge monitor checks them.
module tb_csr_spi_host;

  localparam int D = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       req_valid, req_ready, req_write;
  logic [5:0] req_addr;
  logic [7:0] req_wdata, rsp_rdata;
  logic       rsp_valid, busy, spi_sclk, spi_cs_n, spi_mosi;
  logic       spi_miso = 1'b1;

  logic       req_valid_1, req_ready_1, req_write_1;
  logic [5:0] req_addr_1;
  logic [7:0] req_wdata_1, rsp_rdata_1;
  logic       rsp_valid_1, busy_1, spi_sclk_1, spi_cs_n_1, spi_mosi_1;

  csr_spi_host #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  csr_spi_host #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid_1), .req_ready(req_ready_1),
    .req_write(req_write_1), .req_addr(req_addr_1), .req_wdata(req_wdata_1),
    .rsp_valid(rsp_valid_1), .rsp_rdata(rsp_rdata_1), .busy(busy_1),
    .spi_sclk(spi_sclk_1), .spi_cs_n(spi_cs_n_1), .spi_mosi(spi_mosi_1), .spi_miso(1'b1)
  );

  typedef struct {
    logic [23:0] mosi;
    int          nbits;
    logic [7:0]  rdata;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  int         rsp_cnt = 0;
  logic [7:0] last_rdata = 8'h00;
  logic [7:0] miso_byte = 8'hFF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor + slave model: collects MOSI on SCLK rise, drives MISO after SCLK fall.
  logic        prev_cs = 1'b1, prev_sclk = 1'b0, had_frame = 1'b0;
  logic [23:0] bits = '0;
  int          nbits = 0, cs_low = 0, cs_high = 0, sidx = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid) begin
      rsp_cnt++;
      if (sb.size() == 0) check("rsp_unexpected_queue", sb.size(), 1);
      else begin
        e = sb.pop_front();
        check("frame_bits", nbits, e.nbits);
        check("frame_mosi", bits, e.mosi);
        check("cs_low_cycles", cs_low, 2 * D * e.nbits + D);
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("cs_at_rsp", spi_cs_n, 1);
      end
    end
    if (!spi_cs_n) begin
      if (prev_cs) begin
        if (had_frame) check("cs_gap_ok", cs_high >= D, 1);
        had_frame = 1'b1;
        bits = '0; nbits = 0; cs_low = 0; sidx = 0; cs_high = 0;
      end
      cs_low++;
      if (!prev_sclk && spi_sclk) begin
        bits = {bits[22:0], spi_mosi};
        nbits++;
      end
      if (prev_sclk && !spi_sclk) sidx++;
    end else begin
      cs_high++;
    end
    spi_miso = (sidx >= 16 && sidx < 24) ? miso_byte[23 - sidx] : 1'b1;
    prev_cs   = spi_cs_n;
    prev_sclk = spi_sclk;
  end

  task automatic send(input bit w, input logic [5:0] a, input logic [7:0] d, input logic [7:0] mb);
    exp_t e;
    int n = 0;
    @(negedge clk);
    req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    while (!req_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", req_ready, 1);
    miso_byte = mb;
    e.nbits = w ? 16 : 24;
    e.mosi  = w ? {8'h00, 2'b10, a, d} : {2'b01, a, 16'h0000};
    if (!w) last_rdata = mb;
    e.rdata = last_rdata;
    sb.push_back(e);
    @(posedge clk);
  endtask

  task automatic drop();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sb.size() != 0 || !req_ready) && n < 2000);
    check("idle_reached", (sb.size() == 0) && req_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, n, sclk_err;
    logic [15:0] bits1;
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    req_valid_1 = 0; req_write_1 = 0; req_addr_1 = '0; req_wdata_1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_busy", busy, 0);
    check("rst_sclk", spi_sclk, 0);
    check("rst_cs_n", spi_cs_n, 1);
    check("rst_mosi", spi_mosi, 0);
    rst = 1'b0;

    send(1, 6'h1B, 8'hA5, 8'hFF); drop(); wait_idle();
    send(0, 6'h03, 8'h00, 8'h3C); drop(); wait_idle();
    send(1, 6'h1B, 8'h5A, 8'hFF); drop(); wait_idle();

    repeat (8) begin
      send(1'($urandom_range(0, 1)), 6'($urandom), 8'($urandom), 8'($urandom));
      drop(); wait_idle();
    end

    // Back-to-back with req_valid held high across both requests.
    c0 = rsp_cnt;
    send(1, 6'h11, 8'h22, 8'hFF);
    send(1, 6'h2C, 8'hC3, 8'hFF);
    drop(); wait_idle();
    check("b2b_rsp_count", rsp_cnt - c0, 2);

    // A request pulsed mid-frame must be dropped.
    c0 = rsp_cnt;
    send(0, 6'h07, 8'h00, 8'h96); drop();
    repeat (20) @(negedge clk);
    check("busy_ready_low", req_ready, 0);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 6'h3F; req_wdata = 8'hEE;
    @(negedge clk);
    req_valid = 1'b0;
    wait_idle();
    repeat (10) @(negedge clk);
    check("busy_rsp_count", rsp_cnt - c0, 1);
    check("busy_no_extra_frame", busy, 0);

    // Reset around bit 10 of a read.
    send(0, 6'h2A, 8'h00, 8'hC3); drop();
    repeat (41) @(negedge clk);
    check("mid_frame_cs", spi_cs_n, 0);
    rst = 1'b1;
    @(posedge clk);
    sb.delete();
    last_rdata = 8'h00;
    #1;
    check("abort_cs_n", spi_cs_n, 1);
    check("abort_sclk", spi_sclk, 0);
    check("abort_mosi", spi_mosi, 0);
    check("abort_ready", req_ready, 1);
    check("abort_rsp", rsp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    send(0, 6'h15, 8'h00, 8'h81); drop(); wait_idle();

    // CLK_DIV=1 instance: SCLK toggles every clk.
    req_write_1 = 1'b1; req_addr_1 = 6'h15; req_wdata_1 = 8'h6E;
    @(negedge clk);
    req_valid_1 = 1'b1;
    check("d1_ready", req_ready_1, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid_1 = 1'b0;
    n = 0; sclk_err = 0; bits1 = '0;
    while (!spi_cs_n_1 && n < 100) begin
      if (spi_sclk_1 !== ((n < 32) && (n % 2 == 1))) sclk_err++;
      if (spi_sclk_1) bits1 = {bits1[14:0], spi_mosi_1};
      n++;
      @(negedge clk);
    end
    check("d1_cs_low", n, 33);
    check("d1_sclk_pattern_errs", sclk_err, 0);
    check("d1_mosi", bits1, 16'h956E);
    check("d1_rsp_valid", rsp_valid_1, 1);
    check("d1_rdata_kept", rsp_rdata_1, 0);
    @(negedge clk);
    check("d1_rsp_pulse_end", rsp_valid_1, 0);
    check("d1_ready_back", req_ready_1, 1);

    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
